// File: rtl/shazam_pkg.sv
// Shared types and constants for the shazam frame sequencer.
package shazam_pkg;

    // Words shifted out by the serializer per frame.
    localparam int unsigned FRAME_WORDS = 16;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned FRAME_CNT_W   = 16;
    localparam int unsigned DROP_CNT_W    = 8;
    localparam int unsigned TIMEOUT_CNT_W = 8;
    localparam int unsigned PHASE_CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        StIdle     = 3'd0,
        StArm      = 3'd1,
        StWaitCore = 3'd2,
        StLoad     = 3'd3,
        StDrain    = 3'd4,
        StGap      = 3'd5
    } seq_state_t;

    // Increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/shazam_sequencer.sv
// Frame sequencer: starts the analysis core, hands results to the serializer,
// and paces frames with an idle gap, a watchdog and drop/timeout statistics.
module shazam_sequencer
    import shazam_pkg::*;
#(
    parameter int unsigned TIMEOUT_W  = 22,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic                     run_i,
    input  logic                     maximas_found_i,
    input  logic                     piso_active_i,
    input  logic                     fifo_wfull_i,
    output logic                     core_start_o,
    output logic                     piso_load_o,
    output logic                     busy_o,
    output logic [FRAME_CNT_W-1:0]   frame_count_o,
    output logic [DROP_CNT_W-1:0]    drop_count_o,
    output logic [TIMEOUT_CNT_W-1:0] timeout_count_o,
    output logic [STATE_W-1:0]       state_dbg_o
);

    // Watchdog fires on the cycle whose next count would be all-ones, so the
    // GAP state appears exactly 2^TIMEOUT_W-1 cycles after core_start.
    localparam logic [TIMEOUT_W-1:0]   WdFire  = ~(TIMEOUT_W'(1));
    localparam logic [PHASE_CNT_W-1:0] GapLast = PHASE_CNT_W'(GAP_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] DrainMin = PHASE_CNT_W'(2);

    seq_state_t               state_q;
    logic                     single_q;
    logic                     core_start_q;
    logic                     piso_load_q;
    logic [TIMEOUT_W-1:0]     wd_q;
    // Shared by DRAIN (minimum dwell) and GAP (idle spacing).
    logic [PHASE_CNT_W-1:0]   phase_q;
    logic [FRAME_CNT_W-1:0]   frame_q;
    logic [DROP_CNT_W-1:0]    drop_q;
    logic [TIMEOUT_CNT_W-1:0] timeout_q;

    // Sequencer FSM with registered one-cycle pulses and statistics counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            single_q     <= 1'b0;
            core_start_q <= 1'b0;
            piso_load_q  <= 1'b0;
            wd_q         <= '0;
            phase_q      <= '0;
            frame_q      <= '0;
            drop_q       <= '0;
            timeout_q    <= '0;
        end else begin
            core_start_q <= 1'b0;
            piso_load_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i || run_i) begin
                        single_q <= start_i;
                        state_q  <= StArm;
                    end
                end
                StArm: begin
                    // Only kick the core when the result has somewhere to go.
                    if (!fifo_wfull_i && !piso_active_i) begin
                        core_start_q <= 1'b1;
                        wd_q         <= '0;
                        state_q      <= StWaitCore;
                    end
                end
                StWaitCore: begin
                    wd_q <= wd_q + TIMEOUT_W'(1);
                    if (maximas_found_i) begin
                        phase_q <= '0;
                        if (fifo_wfull_i) begin
                            drop_q  <= sat_inc8(drop_q);
                            state_q <= StGap;
                        end else begin
                            piso_load_q <= 1'b1;
                            frame_q     <= frame_q + FRAME_CNT_W'(1);
                            state_q     <= StLoad;
                        end
                    end else if (wd_q == WdFire) begin
                        timeout_q <= sat_inc8(timeout_q);
                        phase_q   <= '0;
                        state_q   <= StGap;
                    end
                end
                StLoad: begin
                    phase_q <= '0;
                    state_q <= StDrain;
                end
                StDrain: begin
                    // piso_active may lag the load; ignore it for two cycles.
                    if (phase_q >= DrainMin && !piso_active_i) begin
                        phase_q <= '0;
                        state_q <= StGap;
                    end else if (phase_q < DrainMin) begin
                        phase_q <= phase_q + PHASE_CNT_W'(1);
                    end
                end
                StGap: begin
                    if (phase_q == GapLast) begin
                        if (run_i && !single_q) begin
                            state_q <= StArm;
                        end else begin
                            single_q <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end else begin
                        phase_q <= phase_q + PHASE_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        core_start_o    = core_start_q;
        piso_load_o     = piso_load_q;
        busy_o          = (state_q != StIdle);
        frame_count_o   = frame_q;
        drop_count_o    = drop_q;
        timeout_count_o = timeout_q;
        state_dbg_o     = state_q;
    end

endmodule

// File: tb/tb_shazam_sequencer.sv
// Self-checking bench for shazam_sequencer: the bench plays the analysis core
// and serializer, and predicts timing and counters from the frame rules.
module tb_shazam_sequencer;
    import shazam_pkg::*;

    localparam int GAP = 16;
    localparam logic [2:0] SIdle  = 3'(StIdle);
    localparam logic [2:0] SArm   = 3'(StArm);
    localparam logic [2:0] SWait  = 3'(StWaitCore);
    localparam logic [2:0] SLoad  = 3'(StLoad);
    localparam logic [2:0] SDrain = 3'(StDrain);
    localparam logic [2:0] SGap   = 3'(StGap);

    logic clk = 1'b0;
    logic reset, start, run, maximas_found, piso_active, fifo_wfull;

    logic        cs_a, pl_a, busy_a, cs_b, pl_b, busy_b;
    logic [15:0] fc_a, fc_b;
    logic [7:0]  dc_a, dc_b, tc_a, tc_b;
    logic [2:0]  st_a, st_b;

    int total = 0;
    int bad = 0;
    int viol = 0;
    int cyc = 0;

    // Main instance with the default watchdog width.
    shazam_sequencer #(.TIMEOUT_W(22), .GAP_CYCLES(GAP)) dut_a (
        .clk_i(clk), .reset_i(reset), .start_i(start), .run_i(run),
        .maximas_found_i(maximas_found), .piso_active_i(piso_active),
        .fifo_wfull_i(fifo_wfull), .core_start_o(cs_a), .piso_load_o(pl_a),
        .busy_o(busy_a), .frame_count_o(fc_a), .drop_count_o(dc_a),
        .timeout_count_o(tc_a), .state_dbg_o(st_a)
    );

    // Short watchdog instance for the timeout scenarios.
    shazam_sequencer #(.TIMEOUT_W(6), .GAP_CYCLES(GAP)) dut_b (
        .clk_i(clk), .reset_i(reset), .start_i(start), .run_i(run),
        .maximas_found_i(maximas_found), .piso_active_i(piso_active),
        .fifo_wfull_i(fifo_wfull), .core_start_o(cs_b), .piso_load_o(pl_b),
        .busy_o(busy_b), .frame_count_o(fc_b), .drop_count_o(dc_b),
        .timeout_count_o(tc_b), .state_dbg_o(st_b)
    );

    always #10 clk = ~clk;

    // Pulse exclusivity and no load into a busy serializer, every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (cs_a && pl_a) viol++;
            if (pl_a && piso_active) viol++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout sim did not finish cyc=%0d", cyc);
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; run = 1'b0;
        maximas_found = 1'b0; piso_active = 1'b0; fifo_wfull = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_cs(input bit use_b, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (use_b ? cs_b : cs_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Serializer model: called in the LOAD cycle; returns the cycle DRAIN exits.
    task automatic serve_drain(input int dur, output int x);
        int d;
        step();
        d = cyc;
        if (dur > 0) begin
            piso_active = 1'b1;
            repeat (dur) step();
            piso_active = 1'b0;
        end
        x = (dur > 2) ? d + dur : d + 2;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; run = 1'b1; maximas_found = 1'b1;
        piso_active = 1'b0; fifo_wfull = 1'($urandom_range(0, 1));
        step();
        step();
        total++; if (st_a !== SIdle) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", st_a, SIdle); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_a); end
        total++; if (cs_a !== 1'b0 || pl_a !== 1'b0) begin bad++; $display("FAIL reset_pulses cs=%0b pl=%0b exp=0", cs_a, pl_a); end
        total++; if (fc_a !== 16'd0 || dc_a !== 8'd0 || tc_a !== 8'd0) begin bad++; $display("FAIL reset_counters fc=%0d dc=%0d tc=%0d exp=0", fc_a, dc_a, tc_a); end
        total++; if (st_b !== SIdle) begin bad++; $display("FAIL reset_state_b got=%0d exp=%0d", st_b, SIdle); end
        do_reset();
    endtask

    task automatic test_single_shot();
        bit ok;
        int c, x, dur;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (st_a !== SArm || busy_a !== 1'b1) begin bad++; $display("FAIL ss_arm state=%0d busy=%0b exp=%0d/1", st_a, busy_a, SArm); end
        wait_cs(1'b0, 5, ok);
        total++; if (!ok) begin bad++; $display("FAIL ss_core_start got=none exp=pulse"); end
        c = cyc;
        step_to(c + 100);
        maximas_found = 1'b1;
        step();
        maximas_found = 1'b0;
        total++; if (pl_a !== 1'b1 || cyc != c + 101) begin bad++; $display("FAIL ss_load_latency pl=%0b cyc=%0d exp=1@%0d", pl_a, cyc, c + 101); end
        total++; if (fc_a !== 16'd1 || st_a !== SLoad) begin bad++; $display("FAIL ss_frame_count fc=%0d st=%0d exp=1/%0d", fc_a, st_a, SLoad); end
        dur = $urandom_range(5, FRAME_WORDS + 9);
        serve_drain(dur, x);
        // A start pulse during GAP must be ignored.
        step_to(x + 3);
        start = 1'b1;
        step();
        start = 1'b0;
        step_to(x + GAP);
        total++; if (st_a !== SGap) begin bad++; $display("FAIL ss_gap_end got=%0d exp=%0d", st_a, SGap); end
        step();
        total++; if (st_a !== SIdle || busy_a !== 1'b0) begin bad++; $display("FAIL ss_idle state=%0d busy=%0b exp=%0d/0", st_a, busy_a, SIdle); end
        repeat (20) step();
        total++; if (st_a !== SIdle || fc_a !== 16'd1) begin bad++; $display("FAIL ss_start_ignored state=%0d fc=%0d exp=%0d/1", st_a, fc_a, SIdle); end
    endtask

    task automatic test_run();
        bit ok;
        int c, x, x_prev, lat, dur;
        do_reset();
        run = 1'b1;
        x_prev = 0;
        x = 0;
        for (int f = 0; f < 3; f++) begin
            wait_cs(1'b0, (f == 0) ? 5 : GAP + 40, ok);
            total++; if (!ok) begin bad++; $display("FAIL run_core_start frame=%0d got=none exp=pulse", f); end
            if (f > 0) begin
                total++; if (cyc != x_prev + GAP + 2) begin bad++; $display("FAIL run_spacing frame=%0d got=%0d exp=%0d", f, cyc - x_prev, GAP + 2); end
            end
            c = cyc;
            lat = $urandom_range(2, 40);
            if (f == 0) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
            step_to(c + lat);
            maximas_found = 1'b1;
            step();
            maximas_found = 1'b0;
            total++; if (pl_a !== 1'b1 || fc_a !== 16'(f + 1)) begin bad++; $display("FAIL run_load frame=%0d pl=%0b fc=%0d exp=1/%0d", f, pl_a, fc_a, f + 1); end
            if (f == 2) run = 1'b0;
            dur = (f == 1) ? 0 : $urandom_range(0, FRAME_WORDS + 9);
            serve_drain(dur, x);
            x_prev = x;
        end
        step_to(x + GAP + 1);
        total++; if (st_a !== SIdle || fc_a !== 16'd3) begin bad++; $display("FAIL run_end state=%0d fc=%0d exp=%0d/3", st_a, fc_a, SIdle); end
    endtask

    task automatic test_drop();
        bit ok, seen;
        int c, g, hold, lat;
        do_reset();
        run = 1'b1;
        fifo_wfull = 1'b1;
        step();
        seen = 1'b0;
        hold = $urandom_range(5, 30);
        for (int i = 0; i < hold; i++) begin
            step();
            if (cs_a) seen = 1'b1;
        end
        total++; if (seen || st_a !== SArm) begin bad++; $display("FAIL drop_arm_hold cs_seen=%0b st=%0d exp=0/%0d", seen, st_a, SArm); end
        fifo_wfull = 1'b0;
        wait_cs(1'b0, 3, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_core_start got=none exp=pulse"); end
        c = cyc;
        lat = $urandom_range(1, 20);
        step_to(c + lat);
        maximas_found = 1'b1;
        fifo_wfull = 1'b1;
        step();
        maximas_found = 1'b0;
        fifo_wfull = 1'b0;
        g = cyc;
        total++; if (pl_a !== 1'b0 || dc_a !== 8'd1 || fc_a !== 16'd0) begin bad++; $display("FAIL drop_count pl=%0b dc=%0d fc=%0d exp=0/1/0", pl_a, dc_a, fc_a); end
        total++; if (st_a !== SGap) begin bad++; $display("FAIL drop_gap got=%0d exp=%0d", st_a, SGap); end
        run = 1'b0;
        step_to(g + GAP);
        total++; if (st_a !== SIdle) begin bad++; $display("FAIL drop_idle got=%0d exp=%0d", st_a, SIdle); end
    endtask

    task automatic test_timeout();
        bit ok;
        int c;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_cs(1'b1, 5, ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_core_start got=none exp=pulse"); end
        c = cyc;
        step_to(c + 62);
        total++; if (st_b !== SWait) begin bad++; $display("FAIL tmo_wait got=%0d exp=%0d", st_b, SWait); end
        step();
        total++; if (st_b !== SGap || tc_b !== 8'd1) begin bad++; $display("FAIL tmo_fire st=%0d tc=%0d exp=%0d/1", st_b, tc_b, SGap); end
        step_to(c + 63 + GAP);
        total++; if (st_b !== SIdle) begin bad++; $display("FAIL tmo_idle got=%0d exp=%0d", st_b, SIdle); end
        start = 1'b1;
        step();
        start = 1'b0;
        wait_cs(1'b1, 5, ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_core_start2 got=none exp=pulse"); end
        c = cyc;
        step_to(c + 62);
        maximas_found = 1'b1;
        step();
        maximas_found = 1'b0;
        total++; if (st_b !== SLoad || pl_b !== 1'b1) begin bad++; $display("FAIL tmo_tie_load st=%0d pl=%0b exp=%0d/1", st_b, pl_b, SLoad); end
        total++; if (tc_b !== 8'd1 || fc_b !== 16'd1) begin bad++; $display("FAIL tmo_tie_counts tc=%0d fc=%0d exp=1/1", tc_b, fc_b); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        run = 1'b1;
        wait_cs(1'b0, 5, ok);
        maximas_found = 1'b1;
        step();
        maximas_found = 1'b0;
        step();
        piso_active = 1'b1;
        step();
        step();
        total++; if (st_a !== SDrain || fc_a !== 16'd1) begin bad++; $display("FAIL rmid_pre_drain st=%0d fc=%0d exp=%0d/1", st_a, fc_a, SDrain); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        piso_active = 1'b0;
        run = 1'b0;
        total++; if (st_a !== SIdle || fc_a !== 16'd0 || cs_a !== 1'b0 || pl_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL rmid_drain st=%0d fc=%0d cs=%0b pl=%0b busy=%0b exp=0", st_a, fc_a, cs_a, pl_a, busy_a); end
        run = 1'b1;
        wait_cs(1'b0, 5, ok);
        maximas_found = 1'b1;
        fifo_wfull = 1'b1;
        step();
        maximas_found = 1'b0;
        fifo_wfull = 1'b0;
        wait_cs(1'b0, GAP + 5, ok);
        repeat (3) step();
        total++; if (!ok || st_a !== SWait || dc_a !== 8'd1) begin bad++; $display("FAIL rmid_pre_wait ok=%0b st=%0d dc=%0d exp=1/%0d/1", ok, st_a, dc_a, SWait); end
        reset = 1'b1;
        maximas_found = 1'b1;
        step();
        reset = 1'b0;
        maximas_found = 1'b0;
        run = 1'b0;
        total++; if (st_a !== SIdle || dc_a !== 8'd0 || pl_a !== 1'b0 || cs_a !== 1'b0) begin bad++; $display("FAIL rmid_wait st=%0d dc=%0d pl=%0b cs=%0b exp=0", st_a, dc_a, pl_a, cs_a); end
        repeat (5) step();
        total++; if (st_a !== SIdle || pl_a !== 1'b0 || cs_a !== 1'b0) begin bad++; $display("FAIL rmid_quiet st=%0d pl=%0b cs=%0b exp=0", st_a, pl_a, cs_a); end
    endtask

    task automatic test_saturation();
        bit ok;
        int exp_dc;
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            wait_cs(1'b0, GAP + 10, ok);
            if (!ok) begin
                total++; bad++;
                $display("FAIL sat_core_start drop=%0d got=none exp=pulse", i);
                break;
            end
            maximas_found = 1'b1;
            fifo_wfull = 1'b1;
            step();
            maximas_found = 1'b0;
            fifo_wfull = 1'b0;
            exp_dc = (i > 255) ? 255 : i;
            if (i == 3 || i == 254 || i == 255 || i == 300) begin
                total++; if (dc_a !== 8'(exp_dc) || pl_a !== 1'b0) begin bad++; $display("FAIL sat_drop_count drop=%0d dc=%0d pl=%0b exp=%0d/0", i, dc_a, pl_a, exp_dc); end
            end
        end
        run = 1'b0;
        total++; if (fc_a !== 16'd0) begin bad++; $display("FAIL sat_no_frames fc=%0d exp=0", fc_a); end
    endtask

    task automatic test_invariants();
        total++; if (viol != 0) begin bad++; $display("FAIL pulse_invariants violations=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_run();
        test_drop();
        test_timeout();
        test_reset_mid();
        test_saturation();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shazam_sequencer.md
SHAZAM_SEQUENCER -- requirements
Module: shazam_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 22, width of the per-frame watchdog counter; a timeout fires at 2^TIMEOUT_W-1 cycles.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, the number of idle cycles between consecutive frames; legal range is 1..255.
REQ-003 clk  in  1  system clock (50 MHz domain).
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  single-shot request pulse: analyse one frame.
REQ-006 run  in  1  level: analyse frames continuously while high.
REQ-007 maximas_found  in  1  one-cycle pulse from the core: maxima bus valid and held until the next core_start.
REQ-008 piso_active  in  1  serializer output_active.
REQ-009 fifo_wfull  in  1  write-side full flag of the dual-clock FIFO.
REQ-010 core_start  out  1  one-cycle start pulse to the analysis core.
REQ-011 piso_load  out  1  one-cycle load pulse to the serializer.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 frame_count  out  16  frames delivered to the serializer; wraps.
REQ-014 drop_count  out  8  frames discarded due to a full FIFO; saturates at 255.
REQ-015 timeout_count  out  8  watchdog expiries; saturates at 255.
REQ-016 state_dbg  out  3  current state encoding.

Function
REQ-017 SHALL implement states IDLE, ARM, WAIT_CORE, LOAD, DRAIN, GAP.
REQ-018 IDLE->ARM when start=1 or run=1; start latches a single-shot flag.
REQ-019 ARM: stay while fifo_wfull=1 or piso_active=1; otherwise assert core_start for exactly one cycle, clear the watchdog, and go to WAIT_CORE.
REQ-020 WAIT_CORE: on maximas_found=1 with fifo_wfull=0 ->LOAD; with fifo_wfull=1 ->GAP, drop_count+1, no piso_load.
REQ-021 WAIT_CORE: on watchdog reaching max ->GAP, timeout_count+1; if maximas_found arrives in that same cycle, maximas_found wins.
REQ-022 LOAD: assert piso_load for one cycle, frame_count+1, ->DRAIN; latency from maximas_found to piso_load is exactly 1 cycle.
REQ-023 DRAIN: exit to GAP on the first cycle piso_active=0 that is at least 2 cycles after DRAIN entry.
REQ-024 GAP: count GAP_CYCLES, then ->ARM if run=1 and the single-shot flag is clear; otherwise clear the flag and ->IDLE.
REQ-025 Deasserting run mid-frame SHALL NOT abort the frame; the frame completes and the block returns to IDLE after GAP.
REQ-026 start pulses while busy=1 SHALL be ignored.
REQ-027 core_start and piso_load SHALL never be high in the same cycle.
REQ-028 The serializer SHALL never be loaded while piso_active=1.

Reset
REQ-029 On reset: state=IDLE, all outputs 0, all counters 0, watchdog 0, single-shot flag clear, all regardless of current state.
REQ-030 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-031 Shared package shazam_pkg SHALL hold the state enum (seq_state_t), FRAME_WORDS=16, and counter widths.
REQ-032 The watchdog, GAP counter and saturating counters SHALL be inline logic; no sub-module is required.

Verification
REQ-033 Single-shot: start pulse, maximas_found 100 cycles after core_start -> piso_load 1 cycle later, frame_count=1, IDLE after DRAIN+16 gap cycles.
REQ-034 Continuous run with 3 frames -> 3 core_start pulses, each spaced ≥16 cycles after the previous piso_active fall; frame_count=3.
REQ-035 fifo_wfull=1 at maximas_found -> no piso_load, drop_count=1; fifo_wfull held in ARM -> no core_start until it clears.
REQ-036 TIMEOUT_W=6, no maximas_found -> GAP entered 63 cycles after core_start, timeout_count=1; timeout and maximas_found in the same cycle -> LOAD.
REQ-037 Reset asserted in DRAIN and WAIT_CORE -> next cycle IDLE, all counters 0, no pulses.
REQ-038 300 forced drops -> drop_count saturates at 255.
